// File: rtl/pending_encoder_pkg.sv
// pending_encoder_pkg: FSM state type and index-width helper shared by the pending encoder.
package pending_encoder_pkg;
  typedef enum logic {IDLE, PRESENT} pe_state_t;
  function automatic int pe_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pending_encoder_prio_sel.sv
// prio_sel: find-first-set over N bits, searching upward from start and wrapping modulo N.
module prio_sel #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] p;
  always_comb begin
    found = |vec;
    idx = '0;
    p = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = W'((int'(start) + k) % N);
      if (vec[p]) idx = p;
    end
  end
endmodule

// File: rtl/pending_encoder.sv
// pending_encoder: sticky event capture with valid/ready index presentation.
// PENDING_ENCODER_RR_EN selects round-robin priority; otherwise lowest index wins.
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = pe_clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic [N-1:0] mask,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic [N-1:0] ovf,
  input  logic         ovf_clr
);
  pe_state_t state, state_nx;
  logic [N-1:0] eligible, clr;
  logic [W-1:0] start, sel_idx;
  logic found, hs;
  assign out_valid = state == PRESENT;
  assign hs = out_valid & out_ready;
  assign clr = hs ? N'(1) << out_idx : '0;
  assign eligible = pending & mask;
`ifdef PENDING_ENCODER_RR_EN
  logic [W-1:0] ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= W'(N - 1);
    else if (hs) ptr <= out_idx;
  assign start = (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
`else
  assign start = '0;
`endif
  prio_sel #(.N(N), .W(W)) u_sel (
    .vec  (eligible),
    .start(start),
    .found(found),
    .idx  (sel_idx)
  );
  always_comb state_nx = (state == IDLE) ? (found ? PRESENT : IDLE) : (out_ready ? IDLE : PRESENT);
  // a fresh event on the line being cleared keeps it pending without counting as overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out_idx <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      state   <= state_nx;
      if (state == IDLE && found) out_idx <= sel_idx;
      pending <= (pending & ~clr) | in;
      ovf     <= (ovf & ~{N{ovf_clr}}) | (in & pending & ~clr);
    end
  end
endmodule

// File: tb/tb_pending_encoder.sv
// tb_pending_encoder: randomized and directed stimulus against a queue-based reference model.
module tb_pending_encoder;
  localparam int N = 8;
  localparam int W = 3;
`ifdef PENDING_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst = 1, out_ready = 0, ovf_clr = 0, out_valid;
  logic [N-1:0] in = '0, mask = '0, pending, ovf;
  logic [W-1:0] out_idx;
  int checks = 0, errors = 0;
  int exp_q[$];
  bit [N-1:0] m_pend, m_ovf;
  bit m_valid;
  int m_idx, m_ptr;
  bit fired;

  pending_encoder #(.N(N)) dut (
    .clk(clk), .rst(rst), .in(in), .mask(mask), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .pending(pending),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(bit [N-1:0] e, int from);
    for (int k = 0; k < N; k++) if (e[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_step(bit r, bit [N-1:0] i, bit [N-1:0] m, bit rdy, bit oc);
    bit [N-1:0] keep;
    int sel;
    if (r) begin
      m_pend = '0; m_ovf = '0; m_valid = 0; m_idx = 0; m_ptr = N - 1;
      return;
    end
    keep = m_pend;
    if (m_valid && rdy) keep[m_idx] = 1'b0;
    sel = pick(m_pend & m, RR ? (m_ptr + 1) % N : 0);
    m_ovf = (oc ? '0 : m_ovf) | (i & keep);
    if (m_valid) begin
      if (rdy) begin m_valid = 0; m_ptr = m_idx; end
    end else if (sel >= 0) begin
      m_valid = 1; m_idx = sel;
    end
    m_pend = keep | i;
  endtask

  task automatic step(bit r, bit [N-1:0] i, bit [N-1:0] m, bit rdy, bit oc);
    rst = r; in = i; mask = m; out_ready = rdy; ovf_clr = oc;
    if (!r && m_valid && rdy) exp_q.push_back(m_idx);
    @(negedge clk);
    chk("pending", pending, m_pend);
    chk("ovf", ovf, m_ovf);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) chk("out_idx", out_idx, m_idx);
    model_step(r, i, m, rdy, oc);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handshake got idx %0d expected none", out_idx);
      end else chk("handshake_idx", out_idx, exp_q.pop_front());
    end

  initial begin
    model_step(1, '0, '0, 0, 0);
    @(posedge clk);
    #1;
    repeat (2) step(1, 8'hFF, 8'hFF, 0, 0);
    repeat (3) step(0, 8'hFF, 8'hFF, 0, 0);
    repeat (20) step(0, 8'h00, 8'hFF, 1, 0);
    step(0, 8'b1010_0100, 8'hFF, 1, 0);
    repeat (8) step(0, 8'h00, 8'hFF, 1, 0);
    step(0, 8'h08, 8'hFF, 0, 0);
    repeat (2) step(0, 8'h00, 8'hFF, 0, 0);
    step(0, 8'h40, 8'hF7, 0, 0);
    repeat (2) step(0, 8'h00, 8'hF7, 0, 0);
    repeat (6) step(0, 8'h00, 8'hF7, 1, 0);
    step(0, 8'h10, 8'h00, 0, 0);
    step(0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h10, 8'h00, 0, 0);
    repeat (3) step(0, 8'h00, 8'hFF, 0, 0);
    fired = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, (m_valid && !fired) ? 8'h10 : 8'h00, 8'hEF | {N{fired}}, 1, 0);
      if (m_valid) fired = 1;
    end
    step(0, 8'h00, 8'hFF, 0, 1);
    step(0, 8'h00, 8'hFF, 0, 0);
    repeat (10) step(0, 8'h00, 8'hFF, 1, 0);
    repeat (12) step(0, 8'b0000_0011, 8'hFF, 1, 0);
    repeat (6) step(0, 8'h00, 8'hFF, 1, 0);
    step(0, 8'h20, 8'hFF, 0, 0);
    repeat (3) step(0, 8'h24, 8'hFF, 0, 0);
    step(1, 8'h00, 8'hFF, 1, 0);
    repeat (3) step(0, 8'h00, 8'hFF, 1, 0);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 60) == 0,
           ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
           ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    repeat (20) step(0, 8'h00, 8'hFF, 1, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pending_encoder.md
# pending_encoder

Parametrised, registered priority encoder for N event lines. Single-cycle event pulses are captured into a sticky pending vector; the highest-priority unmasked pending index is presented on a valid/ready output port and cleared when the consumer accepts it. Used as the interrupt/event front end that feeds an index-based consumer, such as a dispatcher or a status FSM.

## Interface
- `N`, default 8: number of event lines; legal range 1..64.
- `W`, default `$clog2(N)` with a minimum of 1: index width. Derived; do not override.

- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `in`  in  N: event pulses. A 1 in any cycle marks that line pending.
- `mask`  in  N: 1 means the line is eligible for selection. Masked lines still capture events.
- `out_idx`  out  W: index being presented.
- `out_valid`  out  1: `out_idx` is valid.
- `out_ready`  in  1: consumer accepts the presented index.
- `pending`  out  N: current sticky pending vector.
- `ovf`  out  N: sticky flag. An event arrived on a line that was already pending.
- `ovf_clr`  in  1: clears all of `ovf`.

## Operation
**Reset values:** `pending`=0, `ovf`=0, `out_valid`=0, `out_idx`=0, state=IDLE, rotate pointer=N-1.

**Capture, every cycle:**
- Next `pending[i]` = (`pending[i]` & ~`clr[i]`) | `in[i]`.
- `clr` is the one-hot of `out_idx`, active only on a handshake (`out_valid` & `out_ready`).
- Set wins over clear. If a new event arrives on a line in the same cycle that line is cleared, the line stays pending and counts as a fresh event, not an overflow.

**Overflow:**
- `ovf[i]` sets when `in[i]` & `pending[i]` & ~`clr[i]`.
- `ovf_clr` clears all bits. If a set and `ovf_clr` occur in the same cycle, the set wins.

**FSM, two states:**
- IDLE:
  - `out_valid`=0.
  - If `eligible` = `pending` & `mask` is non-zero: register the selected index into `out_idx` and go to PRESENT.
  - Otherwise stay in IDLE.
- PRESENT:
  - `out_valid`=1, and `out_idx` is held stable.
  - Changes to `mask` or `pending` do not retract or alter the presented index.
  - On `out_ready`: clear `pending[out_idx]` and go to IDLE.
  - Otherwise stay in PRESENT.

**Selection, default build:** fixed priority. The lowest index wins, so `in[0]` has the highest priority.

**All-zero eligible set:** no output. This is never an X or undefined code.

**Reset mid-operation:** everything returns to the reset values in the same edge. A presented index is dropped, not delivered.

## Timing
- Event-to-valid latency:
  - `in[i]` high in cycle k sets `pending[i]` at edge k.
  - The index is registered at edge k+1.
  - `out_valid` is high during cycle k+1.
- Handshake completes on the edge where `out_valid` & `out_ready` are both 1. `out_valid` is 0 for the next cycle, which is a mandatory bubble.
- Maximum throughput is one index per 2 cycles.
- `out_ready` may be held high permanently and has no combinational path to any output.
- All outputs are registered.

## Configuration
- `PENDING_ENCODER_RR_EN` defined: round-robin priority.
  - A rotate pointer records the last accepted index and is updated on each handshake.
  - Search begins at pointer+1 and wraps modulo N.
  - With N=1 the behaviour is identical to fixed priority.
- Not defined: fixed lowest-index priority, and no pointer register exists.

## Structure
- Shared package `pending_encoder_pkg`:
  - FSM state enum `pe_state_t` {IDLE, PRESENT}.
  - Function `pe_clog2_min1`, used for `W`.
- Sub-module `prio_sel`: combinational find-first-set over N bits with a start offset. Offset is tied to 0 without the macro. Outputs are `found` and `idx`.
- Top-level contains the pending/ovf registers, the FSM, and the rotate pointer.

## Test plan
- Reset then idle, N=8:
  - Hold `rst` 2 cycles with `in`=8'hFF.
  - Expect `pending`=0, `out_valid`=0 during reset.
  - After release, expect `out_idx`=0 valid 2 cycles later.
- Fixed priority drain:
  - Pulse `in`=8'b1010_0100, `mask`=8'hFF, `out_ready`=1.
  - Expect indices 2, 5, 7 on successive handshakes, 2 cycles apart; `pending`=0 at the end.
- Mask and hold:
  - Present index 3 with `out_ready`=0, then drop `mask[3]`.
  - Expect `out_idx`=3 and `out_valid`=1 held.
  - Assert `out_ready`; expect the next eligible index or IDLE.
- Overflow and set-wins:
  - Pulse `in[4]` twice while pending; expect `ovf[4]`=1.
  - Pulse `in[4]` on its handshake cycle; expect `pending[4]` to stay 1 and `ovf[4]` unchanged.
  - Pulse `ovf_clr`; expect `ovf`=0.
- Round-robin (macro on):
  - Keep `in`=8'b0000_0011 re-asserted every cycle with `out_ready`=1.
  - Expect `out_idx` to alternate 0, 1, 0, 1.
  - With the macro off, expect 0 repeatedly.
- Reset mid-PRESENT:
  - Assert `rst` while `out_valid`=1.
  - Expect `out_valid`=0, `pending`=0, `ovf`=0 next cycle and no handshake recorded.
